timer_ctrl: RTL

TIMER_CTRL -- requirements
Module: timer_ctrl

---
 rtl/timer_ctrl_if.sv | 33 +++
 rtl/timer_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/timer_ctrl_if.sv
// Command and display bus of the countdown timer.
// Every signal here is a plain level sampled on each rising edge of clk_tmr;
// there is no valid/ready handshake: commands act in the cycle they are seen
// high, and the outputs are registered values that are valid on every cycle.
interface timer_ctrl_if;
    logic       start;
    logic       pause;
    logic       clear;
    logic       load_en;
    logic [3:0] load_min;
    logic [2:0] load_dec;
    logic [3:0] load_sec;
    logic [9:0] v_index;
    logic [1:0] digit_sel;
    logic [3:0] digit_val;
    logic [1:0] state;
    logic       tick;
    logic       expired;

    // Controller / pixel pipeline side: issues commands, consumes glyph codes.
    modport master (
        output start, pause, clear, load_en, load_min, load_dec, load_sec,
        output v_index, digit_sel,
        input  digit_val, state, tick, expired
    );

    // Timer side.
    modport slave (
        input  start, pause, clear, load_en, load_min, load_dec, load_sec,
        input  v_index, digit_sel,
        output digit_val, state, tick, expired
    );
endinterface

// File: rtl/timer_ctrl.sv
// M:SS countdown timer with a one-second prescaler, a frame-synchronous
// display shadow and a registered glyph-code mux for a VGA font memory.
module timer_ctrl #(
    parameter int unsigned TICK_DIV      = 25000000,
    parameter logic [9:0]  V_BLANK_START = 10'd480,
    parameter logic [3:0]  BLANK_CODE    = 4'hF
) (
    input  logic        clk_tmr,
    input  logic        rst_tmr,
    timer_ctrl_if.slave tif
);
    localparam int          PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_RUN     = 2'b01,
        S_PAUSE   = 2'b10,
        S_EXPIRED = 2'b11
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_min, cnt_sec;
    logic [2:0]    cnt_dec;
    logic [PW-1:0] presc;
    logic [3:0]    disp_min, disp_sec;
    logic [2:0]    disp_dec;
    logic          tick_q, expired_q;
    logic [3:0]    digit_val_q;

    logic          do_zero, do_load, do_count, do_tick;
    logic          cnt_nz, dec_zero;
    logic [3:0]    dec_min, dec_sec;
    logic [2:0]    dec_dec;

    assign cnt_nz   = (cnt_min != 4'd0) || (cnt_dec != 3'd0) || (cnt_sec != 4'd0);
    assign dec_zero = (dec_min == 4'd0) && (dec_dec == 3'd0) && (dec_sec == 4'd0);

    // BCD value one second below the current count (borrow ripples sec -> dec -> min).
    always_comb begin
        dec_min = cnt_min;
        dec_dec = cnt_dec;
        dec_sec = cnt_sec;
        if (cnt_sec != 4'd0) begin
            dec_sec = cnt_sec - 4'd1;
        end else begin
            dec_sec = 4'd9;
            if (cnt_dec != 3'd0) begin
                dec_dec = cnt_dec - 3'd1;
            end else begin
                dec_dec = 3'd5;
                dec_min = cnt_min - 4'd1;
            end
        end
    end

    // Next state and datapath controls; only the highest-priority command acts.
    always_comb begin
        state_d  = state_q;
        do_zero  = 1'b0;
        do_load  = 1'b0;
        do_count = 1'b0;
        do_tick  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (tif.clear) begin
                    do_zero = 1'b1;
                end else if (tif.pause) begin
                    state_d = S_IDLE;
                end else if (tif.start) begin
                    if (cnt_nz) state_d = S_RUN;
                end else if (tif.load_en) begin
                    do_load = 1'b1;
                end
            end
            S_RUN: begin
                if (tif.clear) begin
                    state_d = S_IDLE;
                    do_zero = 1'b1;
                end else if (tif.pause) begin
                    // Freeze immediately: the prescaler does not advance on this edge.
                    state_d = S_PAUSE;
                end else begin
                    do_count = 1'b1;
                    if (presc == PRESC_LAST) begin
                        do_tick = 1'b1;
                        if (dec_zero) state_d = S_EXPIRED;
                    end
                end
            end
            S_PAUSE: begin
                if (tif.clear) begin
                    state_d = S_IDLE;
                    do_zero = 1'b1;
                end else if (tif.pause) begin
                    state_d = S_PAUSE;
                end else if (tif.start) begin
                    state_d = S_RUN;
                end
            end
            S_EXPIRED: begin
                if (tif.clear) begin
                    state_d = S_IDLE;
                    do_zero = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_tmr) begin
        if (rst_tmr) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Working count, prescaler and the tick/expired status flags.
    always_ff @(posedge clk_tmr) begin
        if (rst_tmr) begin
            cnt_min   <= 4'd0;
            cnt_dec   <= 3'd0;
            cnt_sec   <= 4'd0;
            presc     <= '0;
            tick_q    <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            tick_q    <= do_tick;
            expired_q <= (state_d == S_EXPIRED);
            if (do_zero) begin
                cnt_min <= 4'd0;
                cnt_dec <= 3'd0;
                cnt_sec <= 4'd0;
            end else if (do_load) begin
                cnt_min <= (tif.load_min > 4'd9) ? 4'd9 : tif.load_min;
                cnt_dec <= (tif.load_dec > 3'd5) ? 3'd5 : tif.load_dec;
                cnt_sec <= (tif.load_sec > 4'd9) ? 4'd9 : tif.load_sec;
            end else if (do_tick) begin
                cnt_min <= dec_min;
                cnt_dec <= dec_dec;
                cnt_sec <= dec_sec;
            end
            if (do_tick)
                presc <= '0;
            else if (do_count)
                presc <= presc + PW'(1);
            else if ((state_d == S_IDLE) || (state_d == S_EXPIRED))
                presc <= '0;
        end
    end

    // Display shadow follows the count only during vertical blanking; glyph mux behind it.
    always_ff @(posedge clk_tmr) begin
        if (rst_tmr) begin
            disp_min    <= 4'd0;
            disp_dec    <= 3'd0;
            disp_sec    <= 4'd0;
            digit_val_q <= 4'd0;
        end else begin
            if (tif.v_index >= V_BLANK_START) begin
                disp_min <= cnt_min;
                disp_dec <= cnt_dec;
                disp_sec <= cnt_sec;
            end
            case (tif.digit_sel)
                2'b11:   digit_val_q <= disp_min;
                2'b10:   digit_val_q <= {1'b0, disp_dec};
                2'b01:   digit_val_q <= disp_sec;
                default: digit_val_q <= BLANK_CODE;
            endcase
        end
    end

    assign tif.state     = state_q;
    assign tif.tick      = tick_q;
    assign tif.expired   = expired_q;
    assign tif.digit_val = digit_val_q;
endmodule
